btn_operand_entry: RTL and testbench
====================================

Name: btn_operand_entry

Overview:
- Front-panel input responder for the RISC-V CPU top level.
- Receives the five raw push-button levels (center/up/down/left/right). It synchronizes, debounces and edge-detects each one.
- Up/down/left/right edit a 32-bit operand, one hex digit at a time.
- Center latches the operand and issues a one-cycle calc_start to the CPU, then holds off further edits until the CPU reports done.

Parameters:
- DEBOUNCE_CYCLES, 8, consecutive stable cycles required before a debounced level change is accepted (>=2).
- REPEAT_DELAY, 64, cycles up/down must be held before the first auto-repeat (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeats (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- btn_center_in  in  1  raw button, active high, asynchronous
- btn_up_in  in  1  raw button
- btn_down_in  in  1  raw button
- btn_left_in  in  1  raw button
- btn_right_in  in  1  raw button
- calc_done  in  1  one-cycle pulse from CPU: computation finished
- operand  out  32  live edit value (digit k = bits 4k+3:4k)
- cursor  out  3  index of the digit being edited
- operand_latched  out  32  value captured on the start press
- calc_start  out  1  one-cycle start pulse to the CPU
- busy  out  1  high from calc_start until calc_done

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all synchronizers, debounced states and counters 0, FSM=IDLE. Reset asserted mid-computation aborts to IDLE; no calc_start is emitted on release.
- Sync: each button passes through a 2-flop synchronizer, giving s.
- Debounce, per button:
  - counter clears whenever s == db.
  - When s != db, the counter increments.
  - When the counter = DEBOUNCE_CYCLES-1 and s != db, db <= s and the counter clears.
  - Result: db follows s exactly DEBOUNCE_CYCLES edges after s settles. Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Edge detect: press = db & ~db_d (db_d is db delayed one cycle). One pulse per press; release generates nothing.
- Latency: a raw level sampled high at edge 1 changes operand/cursor at edge DEBOUNCE_CYCLES+3.
- Priority when several press pulses occur in the same cycle: center > up > down > left > right. Only the winner acts; the others are dropped.
- FSM IDLE:
  - up: digit[cursor] <= digit[cursor]+1 mod 16 (F wraps to 0, no carry into the neighbour digit).
  - down: digit[cursor] <= digit[cursor]-1 mod 16 (0 wraps to F).
  - left: cursor <= cursor+1, 7 wraps to 0.
  - right: cursor <= cursor-1, 0 wraps to 7.
  - center: operand_latched <= operand, calc_start=1 for exactly one cycle, busy <= 1, go to BUSY.
- FSM BUSY:
  - All presses are ignored and discarded, not queued. operand and cursor are frozen.
  - calc_done=1: busy <= 0, go to IDLE next cycle.
  - calc_done while IDLE is ignored.
- operand and cursor persist across computations; only reset clears them.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In IDLE, holding up or down (db=1) for REPEAT_DELAY cycles after its press pulse generates a synthetic press.
  - Further synthetic presses follow every REPEAT_PERIOD cycles while the button is held.
  - The repeat counter clears on release, on entering BUSY, or when a higher-priority press wins.
  - Left, right and center never repeat.
- Undefined: exactly one action per physical press. REPEAT_DELAY and REPEAT_PERIOD are unused, and no repeat counters are synthesized.

Test Plan:
- Reset, then 5 up presses, 3 left, 1 up, center; each level held 10 cycles high and 10 low -> operand=0x0000_1005, cursor=3, one calc_start pulse, operand_latched=0x0000_1005, busy=1.
- Up held for only DEBOUNCE_CYCLES-2 cycles -> operand unchanged 0x0000_0000, no effect; held 10 cycles -> digit0=1 appears exactly DEBOUNCE_CYCLES+3 edges after the first high sample.
- Wrap-around:
  - 1 down from reset -> operand=0x0000_000F.
  - 1 right -> cursor=7.
  - 16 up presses -> digit7 returns to 0, no carry.
- Center, then up/left presses during BUSY, then calc_done -> operand/cursor unchanged, busy drops next cycle; a subsequent up press edits normally.
- Up and left debounced in the same cycle -> only up applies; center and up together -> only start occurs.
- rst_n pulsed low while busy=1 -> all outputs 0 immediately (asynchronous), no calc_start after release. With BTN_AUTOREPEAT_EN, up held for 64+2*16 cycles -> digit0 = 4 (1 press + 3 repeats).

Source files
------------

// File: rtl/btn_operand_entry_if.sv
// Front-panel bus: raw buttons and CPU done in, operand/cursor/start status out.
// master = panel/CPU side, slave = btn_operand_entry.
interface btn_operand_entry_if;
  logic        btn_center_in;
  logic        btn_up_in;
  logic        btn_down_in;
  logic        btn_left_in;
  logic        btn_right_in;
  logic        calc_done;
  logic [31:0] operand;
  logic [2:0]  cursor;
  logic [31:0] operand_latched;
  logic        calc_start;
  logic        busy;

  modport master (
    output btn_center_in, btn_up_in, btn_down_in, btn_left_in, btn_right_in, calc_done,
    input  operand, cursor, operand_latched, calc_start, busy
  );

  modport slave (
    input  btn_center_in, btn_up_in, btn_down_in, btn_left_in, btn_right_in, calc_done,
    output operand, cursor, operand_latched, calc_start, busy
  );
endinterface

// File: rtl/btn_operand_entry.sv
// Push-button hex operand editor: sync + debounce + edge detect per button, IDLE/BUSY start FSM.
// Optional up/down auto-repeat when BTN_AUTOREPEAT_EN is defined.

// Per-button 2-flop synchronizer and stable-count debouncer.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;

  assign s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module btn_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_operand_entry_if.slave bus
);
  localparam int NUM_BTN = 5;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Bit order matches the packed struct: center is the MSB.
  typedef struct packed {
    logic center;
    logic up;
    logic down;
    logic left;
    logic right;
  } btn_t;

  logic [NUM_BTN-1:0] raw_vec, db_vec, db_d, press_vec;
  btn_t               pr, act;
  logic               up_eff, down_eff;

  logic [0:0]  state;
  logic [31:0] operand, operand_latched;
  logic [2:0]  cursor;
  logic        calc_start;

  assign raw_vec = {bus.btn_center_in, bus.btn_up_in, bus.btn_down_in,
                    bus.btn_left_in, bus.btn_right_in};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw_vec),
    .db    (db_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_d <= '0;
    else        db_d <= db_vec;
  end

  assign press_vec = db_vec & ~db_d;
  assign pr        = btn_t'(press_vec);

`ifdef BTN_AUTOREPEAT_EN
  localparam int B_UP   = 3;
  localparam int B_DOWN = 2;
  localparam int RW     = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  // Lane 1 = up, lane 0 = down; counter holds cycles since the press pulse.
  logic [1:0][RW-1:0] rpt_cnt;
  logic [1:0]         rpt_held, rpt_kill, rpt_fire;

  assign rpt_held    = {db_vec[B_UP], db_vec[B_DOWN]};
  assign rpt_fire[1] = rpt_held[1] && (rpt_cnt[1] == RPT_FIRE);
  assign rpt_fire[0] = rpt_held[0] && (rpt_cnt[0] == RPT_FIRE);
  assign up_eff      = pr.up   | rpt_fire[1];
  assign down_eff    = pr.down | rpt_fire[0];
  assign rpt_kill[1] = (state != S_IDLE) | pr.center;
  assign rpt_kill[0] = (state != S_IDLE) | pr.center | up_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!rpt_held[i] || rpt_kill[i]) rpt_cnt[i] <= '0;
        else if (rpt_fire[i])            rpt_cnt[i] <= RPT_RELOAD;
        else                             rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign up_eff   = pr.up;
  assign down_eff = pr.down;
`endif

  // Single winner per cycle; presses outside IDLE are simply dropped.
  always_comb begin
    act = '0;
    if (state == S_IDLE) begin
      if (pr.center)     act.center = 1'b1;
      else if (up_eff)   act.up     = 1'b1;
      else if (down_eff) act.down   = 1'b1;
      else if (pr.left)  act.left   = 1'b1;
      else if (pr.right) act.right  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      operand         <= '0;
      cursor          <= '0;
      operand_latched <= '0;
      calc_start      <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (act.center) begin
            operand_latched <= operand;
            calc_start      <= 1'b1;
            state           <= S_BUSY;
          end else if (act.up) begin
            operand[{cursor, 2'b00} +: 4] <= operand[{cursor, 2'b00} +: 4] + 4'd1;
          end else if (act.down) begin
            operand[{cursor, 2'b00} +: 4] <= operand[{cursor, 2'b00} +: 4] - 4'd1;
          end else if (act.left) begin
            cursor <= cursor + 3'd1;
          end else if (act.right) begin
            cursor <= cursor - 3'd1;
          end
        end
        S_BUSY: if (bus.calc_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.operand         = operand;
  assign bus.cursor          = cursor;
  assign bus.operand_latched = operand_latched;
  assign bus.calc_start      = calc_start;
  assign bus.busy            = (state == S_BUSY);
endmodule

// File: tb/tb_btn_operand_entry.sv
// Self-checking bench for btn_operand_entry: vector table, hand sequences, random vs reference model.
module tb_btn_operand_entry;
  localparam int DC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_operand_entry_if bus();

  btn_operand_entry #(.DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(64), .REPEAT_PERIOD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;

  always @(negedge clk) if (bus.calc_start === 1'b1) starts++;

  // Reference model: digits, cursor, busy flag, start count.
  logic [31:0] m_op, m_lat;
  int          m_cur, m_base;
  bit          m_busy;
  int          m_starts;

  typedef struct {
    logic [4:0]  mask;
    bit          done;
    logic [31:0] op;
    logic [2:0]  cur;
    bit          busy;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    {bus.btn_center_in, bus.btn_up_in, bus.btn_down_in, bus.btn_left_in, bus.btn_right_in} = m;
  endtask

  // Called 1 time unit after an edge; returns at the same phase.
  task automatic press(input logic [4:0] m, input int hi = 10);
    set_btn(m);
    repeat (hi) @(posedge clk);
    #1 set_btn(5'b0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_done();
    bus.calc_done = 1'b1;
    @(posedge clk);
    #1 bus.calc_done = 1'b0;
  endtask

  task automatic model_reset();
    m_op = '0; m_lat = '0; m_cur = 0; m_busy = 0; m_starts = 0; m_base = starts;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_btn(5'b0);
    bus.calc_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 model_reset();
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v, input int pos, input int delta);
    int d;
    d = int'((v >> (4 * pos)) & 32'hF);
    d = (d + delta + 16) % 16;
    v = v & ~(32'hF << (4 * pos));
    return v | (32'(d) << (4 * pos));
  endfunction

  // First set bit in center,up,down,left,right order wins; nothing happens while busy.
  task automatic m_press(input logic [4:0] m);
    if (m_busy || m == 5'b0) return;
    if (m[4]) begin
      m_lat = m_op; m_busy = 1; m_starts++;
    end else if (m[3]) m_op = bump(m_op, m_cur, 1);
    else if (m[2])     m_op = bump(m_op, m_cur, -1);
    else if (m[1])     m_cur = (m_cur + 1) % 8;
    else               m_cur = (m_cur + 7) % 8;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " operand"}, bus.operand, m_op);
    chk({tag, " cursor"}, 32'(bus.cursor), 32'(m_cur));
    chk({tag, " busy"}, 32'(bus.busy), 32'(m_busy));
    chk({tag, " latched"}, bus.operand_latched, m_lat);
    chk({tag, " starts"}, 32'(starts - m_base), 32'(m_starts));
  endtask

  initial begin
    int base;
    logic [4:0] mask;
    set_btn(5'b0);
    bus.calc_done = 1'b0;

    tbl[0]  = '{5'b01000, 0, 32'h0000_0001, 3'd0, 0};
    tbl[1]  = '{5'b01000, 0, 32'h0000_0002, 3'd0, 0};
    tbl[2]  = '{5'b01000, 0, 32'h0000_0003, 3'd0, 0};
    tbl[3]  = '{5'b01000, 0, 32'h0000_0004, 3'd0, 0};
    tbl[4]  = '{5'b01000, 0, 32'h0000_0005, 3'd0, 0};
    tbl[5]  = '{5'b00010, 0, 32'h0000_0005, 3'd1, 0};
    tbl[6]  = '{5'b00010, 0, 32'h0000_0005, 3'd2, 0};
    tbl[7]  = '{5'b00010, 0, 32'h0000_0005, 3'd3, 0};
    tbl[8]  = '{5'b01000, 0, 32'h0000_1005, 3'd3, 0};
    tbl[9]  = '{5'b10000, 0, 32'h0000_1005, 3'd3, 1};
    tbl[10] = '{5'b01000, 0, 32'h0000_1005, 3'd3, 1};
    tbl[11] = '{5'b00010, 0, 32'h0000_1005, 3'd3, 1};
    tbl[12] = '{5'b00000, 1, 32'h0000_1005, 3'd3, 0};
    tbl[13] = '{5'b01000, 0, 32'h0000_2005, 3'd3, 0};

    // Reset state, observed while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst operand", bus.operand, 32'h0);
    chk("rst cursor", 32'(bus.cursor), 32'h0);
    chk("rst latched", bus.operand_latched, 32'h0);
    chk("rst start", 32'(bus.calc_start), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].done) do_done();
      else             press(tbl[i].mask);
      chk($sformatf("tbl%0d operand", i), bus.operand, tbl[i].op);
      chk($sformatf("tbl%0d cursor", i), 32'(bus.cursor), 32'(tbl[i].cur));
      chk($sformatf("tbl%0d busy", i), 32'(bus.busy), 32'(tbl[i].busy));
    end
    chk("tbl latched", bus.operand_latched, 32'h0000_1005);
    chk("tbl starts", 32'(starts - m_base), 32'd1);

    // Short glitch is filtered; a real press lands exactly DC+3 edges after first sample.
    do_reset();
    set_btn(5'b01000);
    repeat (DC - 2) @(posedge clk);
    #1 set_btn(5'b0);
    repeat (12) @(posedge clk);
    #1 chk("glitch operand", bus.operand, 32'h0);
    set_btn(5'b01000);
    repeat (DC + 2) @(posedge clk);
    #1 chk("latency early", bus.operand, 32'h0);
    @(posedge clk);
    #1 chk("latency edge", bus.operand, 32'h1);
    set_btn(5'b0);
    repeat (12) @(posedge clk);
    #1;

    // Wrap-around of digit value and cursor.
    do_reset();
    press(5'b00100);
    chk("down wrap", bus.operand, 32'h0000_000F);
    press(5'b00001);
    chk("right wrap", 32'(bus.cursor), 32'd7);
    for (int i = 0; i < 15; i++) press(5'b01000);
    chk("up x15", bus.operand, 32'hF000_000F);
    press(5'b01000);
    chk("up wrap no carry", bus.operand, 32'h0000_000F);

    // Simultaneous presses: only the highest priority acts.
    press(5'b01010);
    chk("up+left operand", bus.operand, 32'h1000_000F);
    chk("up+left cursor", 32'(bus.cursor), 32'd7);
    base = starts;
    press(5'b11000);
    chk("center+up operand", bus.operand, 32'h1000_000F);
    chk("center+up busy", 32'(bus.busy), 32'd1);
    chk("center+up starts", 32'(starts - base), 32'd1);
    chk("center+up latched", bus.operand_latched, 32'h1000_000F);
    bus.calc_done = 1'b1;
    chk("busy before done edge", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 bus.calc_done = 1'b0;
    chk("busy after done edge", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of a computation.
    press(5'b10000);
    chk("pre-abort busy", 32'(bus.busy), 32'd1);
    base = starts;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort operand", bus.operand, 32'h0);
    chk("abort cursor", 32'(bus.cursor), 32'h0);
    chk("abort latched", bus.operand_latched, 32'h0);
    chk("abort busy", 32'(bus.busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort no start", 32'(starts - base), 32'd0);
    chk("abort idle", 32'(bus.busy), 32'd0);

    // Random press/done traffic against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        do_done();
        m_busy = 0;
      end else begin
        if (r < 30) mask = 5'($urandom_range(1, 31));
        else        mask = 5'(1 << $urandom_range(0, 4));
        press(mask);
        m_press(mask);
      end
      cmp_model($sformatf("rnd%0d", i));
    end

`ifdef BTN_AUTOREPEAT_EN
    do_reset();
    press(5'b01000, 64 + 2 * 16 + 4);
    chk("autorepeat digit0", bus.operand, 32'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
